i2c_target_wb: RTL and testbench

- I2C target (responder) that lets an external I2C controller on the expansion header read and write the internal 16-bit-address/8-bit-data wishbone register space.
- It is the responder counterpart of the on-board I2C controller and drives a wishbone master port into the bus dispatcher, next to the serial command builder.
- It decodes START, STOP, address and data framing, and stretches SCL while a wishbone cycle is outstanding.

---
 rtl/i2c_target_wb.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_target_wb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_wb.sv
// I2C target bridging an external controller onto the 16-bit-address / 8-bit-data
// wishbone register space; SCL is stretched while a wishbone cycle is outstanding.
module i2c_target_wb #(
    parameter logic [6:0] I2C_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 4,
    parameter int         WB_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_oen,
    output logic        sda_oen,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(WB_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK,
        WDATA, WB_WR, WDATA_ACK, WB_RD, RDATA, RACK, IGNORE
    } state_e;

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0]    s1_q, s2_q, f_q, p_q;
    logic [FW-1:0] cnt_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 2'b11;
            s2_q     <= 2'b11;
            f_q      <= 2'b11;
            p_q      <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            s1_q <= {scl_i, sda_i};
            s2_q <= s1_q;
            p_q  <= f_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    f_q[i]   <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    assign scl_f    = f_q[1];
    assign sda_f    = f_q[0];
    assign scl_rise = scl_f & ~p_q[1];
    assign scl_fall = ~scl_f & p_q[1];
    assign start_c  = scl_f & p_q[1] & p_q[0] & ~sda_f;
    assign stop_c   = scl_f & p_q[1] & ~p_q[0] & sda_f;

    state_e        state_q;
    logic [3:0]    bit_q;
    logic [7:0]    sh_q, hi_q;
    logic [15:0]   ptr_q;
    logic          rw_q, mack_q, scl_oen_q, sda_oen_q;
    logic [TW-1:0] tmo_q;
    logic          wb_cyc_q, wb_stb_q, wb_we_q;
    logic [15:0]   wb_adr_q;
    logic [7:0]    wb_dat_q;

    logic       in_wb, stretch_go, wb_done;
    logic [7:0] rd_byte;
    assign in_wb      = (state_q == WB_WR) || (state_q == WB_RD);
    assign stretch_go = scl_fall & (((state_q == ADDR_ACK) & rw_q) |
                                    ((state_q == WDATA) & (bit_q == 4'd8)) |
                                    ((state_q == RACK) & mack_q));
    assign wb_done    = wb_ack_i || (tmo_q == TW'(WB_TIMEOUT - 1));
    assign rd_byte    = wb_ack_i ? wb_dat_i : 8'hFF;

    // Stretch pulls SCL in the very cycle the fall is seen, ahead of the register
    assign scl_oen  = scl_oen_q & ~stretch_go;
    assign sda_oen  = sda_oen_q;
    assign wb_cyc_o = wb_cyc_q;
    assign wb_stb_o = wb_stb_q;
    assign wb_we_o  = wb_we_q;
    assign wb_adr_o = wb_adr_q;
    assign wb_dat_o = wb_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            sh_q      <= '0;
            hi_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            tmo_q     <= '0;
            scl_oen_q <= 1'b1;
            sda_oen_q <= 1'b1;
            wb_cyc_q  <= 1'b0;
            wb_stb_q  <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_adr_q  <= '0;
            wb_dat_q  <= '0;
        end else begin
            if (!in_wb && !scl_oen_q) scl_oen_q <= 1'b1;
            // SCL is held low throughout a wishbone cycle, so line conditions cannot abort it
            if (start_c && !in_wb) begin
                state_q   <= ADDR;
                bit_q     <= '0;
                sda_oen_q <= 1'b1;
            end else if (stop_c && !in_wb) begin
                state_q   <= IDLE;
                sda_oen_q <= 1'b1;
            end else begin
                if (stretch_go) begin
                    scl_oen_q <= 1'b0;
                    tmo_q     <= '0;
                    wb_cyc_q  <= 1'b1;
                    wb_stb_q  <= 1'b1;
                    wb_adr_q  <= ptr_q;
                    wb_we_q   <= (state_q == WDATA);
                    wb_dat_q  <= (state_q == WDATA) ? sh_q : 8'h00;
                end
                case (state_q)
                    ADDR, PTR_HI, PTR_LO, WDATA: begin
                        if (scl_rise && bit_q != 4'd8) begin
                            sh_q  <= {sh_q[6:0], sda_f};
                            bit_q <= bit_q + 4'd1;
                        end else if (scl_fall && bit_q == 4'd8) begin
                            bit_q <= '0;
                            if (state_q == ADDR) begin
                                if (sh_q[7:1] == I2C_ADDR) begin
                                    sda_oen_q <= 1'b0;
                                    rw_q      <= sh_q[0];
                                    state_q   <= ADDR_ACK;
                                end else begin
                                    state_q   <= IGNORE;
                                end
                            end else if (state_q == PTR_HI) begin
                                hi_q      <= sh_q;
                                sda_oen_q <= 1'b0;
                                state_q   <= PTR_HI_ACK;
                            end else if (state_q == PTR_LO) begin
                                ptr_q     <= {hi_q, sh_q};
                                sda_oen_q <= 1'b0;
                                state_q   <= PTR_LO_ACK;
                            end else begin
                                state_q   <= WB_WR;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        sda_oen_q <= 1'b1;
                        bit_q     <= '0;
                        state_q   <= rw_q ? WB_RD : PTR_HI;
                    end
                    PTR_HI_ACK: if (scl_fall) begin
                        sda_oen_q <= 1'b1;
                        bit_q     <= '0;
                        state_q   <= PTR_LO;
                    end
                    PTR_LO_ACK, WDATA_ACK: if (scl_fall) begin
                        sda_oen_q <= 1'b1;
                        bit_q     <= '0;
                        state_q   <= WDATA;
                    end
                    WB_WR, WB_RD: begin
                        if (wb_done) begin
                            wb_cyc_q <= 1'b0;
                            wb_stb_q <= 1'b0;
                            wb_we_q  <= 1'b0;
                            wb_adr_q <= '0;
                            wb_dat_q <= '0;
                            ptr_q    <= ptr_q + 16'd1;
                            if (state_q == WB_WR) begin
                                sda_oen_q <= ~wb_ack_i;
                                state_q   <= wb_ack_i ? WDATA_ACK : IGNORE;
                            end else begin
                                sda_oen_q <= rd_byte[7];
                                sh_q      <= {rd_byte[6:0], 1'b0};
                                bit_q     <= 4'd1;
                                state_q   <= RDATA;
                            end
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_q == 4'd8) begin
                            sda_oen_q <= 1'b1;
                            state_q   <= RACK;
                        end else begin
                            sda_oen_q <= sh_q[7];
                            sh_q      <= {sh_q[6:0], 1'b0};
                            bit_q     <= bit_q + 4'd1;
                        end
                    end
                    RACK: begin
                        if (scl_rise) mack_q <= ~sda_f;
                        if (scl_fall && !mack_q) state_q <= IGNORE;
                        else if (scl_fall) state_q <= WB_RD;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_wb.sv
// Directed bench: open-drain I2C controller model plus a wishbone responder that logs cycles.
module tb_i2c_target_wb;
    localparam int T = 24;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m_scl = 1'b1, m_sda = 1'b1, ack_en = 1'b1;
    logic        scl_i, sda_i, scl_oen, sda_oen;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [15:0] wb_adr_o;
    logic [7:0]  wb_dat_o, wb_dat_i;

    int checks = 0, errors = 0;
    int cyc_run = 0, cyc_len = 0, dly = 0;
    logic [15:0] q_adr [$];
    logic [7:0]  q_dat [$];
    logic        q_we  [$];
    logic        q_str [$];

    assign scl_i = m_scl & scl_oen;
    assign sda_i = m_sda & sda_oen;

    i2c_target_wb dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
        .scl_oen(scl_oen), .sda_oen(sda_oen),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #4 clk = ~clk;

    // Wishbone responder: acks on the third cycle; read data = 0x10 + adr[7:0]
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            if (wb_cyc_o) cyc_run++;
            else if (cyc_run != 0) begin cyc_len = cyc_run; cyc_run = 0; end
            if (wb_cyc_o && wb_stb_o && ack_en && rst_n) begin
                if (dly == 2) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = 8'h10 + wb_adr_o[7:0];
                    q_adr.push_back(wb_adr_o);
                    q_dat.push_back(wb_dat_o);
                    q_we.push_back(wb_we_o);
                    q_str.push_back(!scl_oen);
                    dly = 0;
                end else dly++;
            end else dly = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_up();
        int n = 0;
        m_scl = 1'b1;
        while (!scl_i && n < 3000) begin wt(1); n++; end
        chk("scl_release", scl_i, 1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wt(T); scl_up(); wt(T);
        m_sda = 1'b0; wt(T); m_scl = 1'b0; wt(T);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wt(T); scl_up(); wt(T); m_sda = 1'b1; wt(T);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wt(T); scl_up(); wt(T); m_scl = 1'b0; wt(4);
        end
        m_sda = 1'b1; wt(T); scl_up(); wt(T/2);
        ack = !sda_i;
        wt(T/2); m_scl = 1'b0; wt(4);
    endtask

    task automatic rd_byte(input logic give_ack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wt(T); scl_up(); wt(T/2); b[i] = sda_i; wt(T/2); m_scl = 1'b0; wt(4);
        end
        m_sda = !give_ack; wt(T); scl_up(); wt(T); m_scl = 1'b0; wt(4); m_sda = 1'b1;
    endtask

    logic       a;
    logic [7:0] rb;
    int         base;
    logic [7:0] wv [5] = '{8'h78, 8'h12, 8'h34, 8'hAB, 8'hCD};
    logic [7:0] rx [3] = '{8'h20, 8'h21, 8'h22};

    initial begin
        wt(5);
        chk("rst_scl_oen", scl_oen, 1);
        chk("rst_sda_oen", sda_oen, 1);
        chk("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1; wt(5);

        // write two bytes at 0x1234
        base = q_adr.size();
        i2c_start();
        for (int i = 0; i < 5; i++) begin
            wr_byte(wv[i], a);
            chk($sformatf("wr_ack%0d", i), a, 1);
        end
        i2c_stop();
        chk("wr_count", q_adr.size() - base, 2);
        chk("wr0_adr", q_adr[base], 16'h1234);
        chk("wr0_dat", q_dat[base], 8'hAB);
        chk("wr0_we", q_we[base], 1);
        chk("wr0_stretch", q_str[base], 1);
        chk("wr1_adr", q_adr[base+1], 16'h1235);
        chk("wr1_dat", q_dat[base+1], 8'hCD);
        chk("wr1_stretch", q_str[base+1], 1);

        // wrong address: NACK, bytes ignored
        base = q_adr.size();
        i2c_start();
        wr_byte(8'h7A, a); chk("bad_addr_nack", a, 0);
        wr_byte(8'h12, a); chk("bad_byte_nack", a, 0);
        i2c_stop();
        chk("bad_no_wb", q_adr.size() - base, 0);

        // set pointer 0x0010, repeated START, read three bytes
        base = q_adr.size();
        i2c_start();
        wr_byte(8'h78, a); chk("rd_addw_ack", a, 1);
        wr_byte(8'h00, a); chk("rd_hi_ack", a, 1);
        wr_byte(8'h10, a); chk("rd_lo_ack", a, 1);
        i2c_start();
        wr_byte(8'h79, a); chk("rd_addr_ack", a, 1);
        for (int i = 0; i < 3; i++) begin
            rd_byte(i != 2, rb);
            chk($sformatf("rd_data%0d", i), rb, rx[i]);
        end
        wt(T);
        chk("rd_rel_sda", sda_oen, 1);
        chk("rd_rel_scl", scl_oen, 1);
        i2c_stop();
        chk("rd_count", q_adr.size() - base, 3);
        chk("rd0_adr", q_adr[base], 16'h0010);
        chk("rd2_adr", q_adr[base+2], 16'h0012);
        chk("rd_we", q_we[base+1], 0);

        // pointer wrap
        base = q_adr.size();
        i2c_start();
        wr_byte(8'h78, a); wr_byte(8'hFF, a); wr_byte(8'hFF, a);
        wr_byte(8'h55, a); chk("wrap_ack0", a, 1);
        wr_byte(8'h66, a); chk("wrap_ack1", a, 1);
        i2c_stop();
        chk("wrap_adr0", q_adr[base], 16'hFFFF);
        chk("wrap_adr1", q_adr[base+1], 16'h0000);
        chk("wrap_dat1", q_dat[base+1], 8'h66);

        // timeouts with ack stuck low; pointer is now 0x0001
        ack_en = 1'b0;
        i2c_start();
        wr_byte(8'h79, a); chk("tmo_raddr_ack", a, 1);
        rd_byte(1'b0, rb);
        chk("tmo_rd_ff", rb, 8'hFF);
        chk("tmo_rd_len", cyc_len, 255);
        i2c_stop();
        i2c_start();
        wr_byte(8'h78, a); wr_byte(8'h00, a);
        wr_byte(8'h50, a); chk("tmo_lo_ack", a, 1);
        wr_byte(8'h99, a); chk("tmo_wr_nack", a, 0);
        chk("tmo_wr_len", cyc_len, 255);
        i2c_stop();
        ack_en = 1'b1;
        base = q_adr.size();
        i2c_start();
        wr_byte(8'h79, a);
        rd_byte(1'b0, rb);
        chk("tmo_ptr_inc_dat", rb, 8'h61);
        i2c_stop();
        chk("tmo_ptr_inc_adr", q_adr[base], 16'h0051);

        // 2-cycle SDA glitch with SCL high must not register as START
        base = q_adr.size();
        m_sda = 1'b0; wt(2); m_sda = 1'b1; wt(T);
        m_scl = 1'b0; wt(T);
        wr_byte(8'h78, a);
        chk("glitch_nack", a, 0);
        chk("glitch_no_wb", q_adr.size() - base, 0);

        // reset while stretching a read
        ack_en = 1'b0;
        i2c_start();
        wr_byte(8'h79, a); chk("rst_rd_ack", a, 1);
        wt(30);
        chk("stretch_scl", scl_oen, 0);
        chk("stretch_cyc", wb_cyc_o, 1);
        rst_n = 1'b0; #1;
        chk("midrst_scl", scl_oen, 1);
        chk("midrst_sda", sda_oen, 1);
        chk("midrst_cyc", wb_cyc_o, 0);
        m_scl = 1'b1; m_sda = 1'b1; ack_en = 1'b1;
        wt(3); rst_n = 1'b1; wt(T);
        base = q_adr.size();
        i2c_start();
        wr_byte(8'h78, a); chk("post_rst_ack", a, 1);
        wr_byte(8'h20, a); wr_byte(8'h00, a);
        wr_byte(8'h5A, a); chk("post_rst_dack", a, 1);
        i2c_stop();
        chk("post_rst_adr", q_adr[base], 16'h2000);
        chk("post_rst_dat", q_dat[base], 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
